// File: rtl/nibble_word_assembler.sv
// nibble_word_assembler
// Collects eight 4-bit digits from a valid/ready stream into one 32-bit word,
// one slot per accepted digit, and offers the finished word on a second
// valid/ready handshake. MSB_FIRST selects whether the first digit lands in
// the lowest slot (0) or the highest slot (1).
module nibble_word_assembler #(
  parameter int MSB_FIRST = 0
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        Start,
  input  logic        Clear,
  input  logic [3:0]  InNib,
  input  logic        InValid,
  output logic        InReady,
  output logic [7:0]  SlotEn,
  output logic [31:0] Word,
  output logic        OutValid,
  input  logic        OutReady,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [2:0]  cnt;
  logic [2:0]  cntNext;
  logic [31:0] wordReg;
  logic [31:0] wordNext;
  logic        busyReg;
  logic        accept;
  logic [2:0]  slotIdx;

  // Map the running digit count onto a word slot according to the fill order.
  function automatic logic [2:0] slotOf(input logic [2:0] c);
    if (MSB_FIRST != 0) begin
      return 3'd7 - c;
    end
    return c;
  endfunction

  // Replace one nibble of a word, leaving the other seven untouched.
  function automatic logic [31:0] insertNib(input logic [31:0] w,
                                            input logic [2:0]  slot,
                                            input logic [3:0]  nib);
    logic [31:0] r;
    r = w;
    for (int i = 0; i < 8; i++) begin
      if (slot == 3'(i)) begin
        r[4*i +: 4] = nib;
      end
    end
    return r;
  endfunction

  assign slotIdx = slotOf(cnt);

  // Accept only while filling; Clear suppresses the write so an aborted
  // digit never strobes a slot.
  assign accept = (state == FILL) && InValid && !Clear;

  // Next-state, counter and word update; Clear overrides every other request.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    wordNext  = wordReg;
    if (Clear) begin
      stateNext = IDLE;
      cntNext   = 3'd0;
      wordNext  = 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            stateNext = FILL;
            cntNext   = 3'd0;
            wordNext  = 32'h0;
          end
        end
        FILL: begin
          if (accept) begin
            wordNext = insertNib(wordReg, slotIdx, InNib);
            cntNext  = cnt + 3'd1;
            if (cnt == 3'd7) begin
              stateNext = HOLD;
            end
          end
        end
        HOLD: begin
          if (OutReady) begin
            if (Start) begin
              stateNext = FILL;
              cntNext   = 3'd0;
              wordNext  = 32'h0;
            end else begin
              stateNext = IDLE;
            end
          end
        end
        default: begin
          stateNext = IDLE;
          cntNext   = 3'd0;
          wordNext  = 32'h0;
        end
      endcase
    end
  end

  // State, counter, word and registered Busy; reset discards any partial word.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      wordReg <= 32'h0;
      busyReg <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      wordReg <= wordNext;
      busyReg <= (stateNext != IDLE);
    end
  end

  // Handshake and strobe outputs decoded from the current state.
  always_comb begin
    InReady  = (state == FILL);
    OutValid = (state == HOLD);
    SlotEn   = accept ? (8'd1 << slotIdx) : 8'd0;
  end

  assign Word = wordReg;
  assign Busy = busyReg;

endmodule

// File: tb/tb_nibble_word_assembler.sv
// Bench for nibble_word_assembler: drives one shared stimulus into an
// LSB-first and an MSB-first instance and compares both against a queue-based
// reference model of the digit stream.
module tb_nibble_word_assembler;

  logic        Clk;
  logic        ResetN;
  logic        Start;
  logic        Clear;
  logic [3:0]  InNib;
  logic        InValid;
  logic        OutReady;

  logic        inReady0, outValid0, busy0;
  logic [7:0]  slotEn0;
  logic [31:0] word0;
  logic        inReady1, outValid1, busy1;
  logic [7:0]  slotEn1;
  logic [31:0] word1;

  int nCmp  = 0;
  int nFail = 0;

  // Reference model: 0 = idle, 1 = filling, 2 = holding; queue of digits.
  int         phase;
  logic [3:0] nibs[$];

  nibble_word_assembler #(.MSB_FIRST(0)) dutLsb (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .Clear(Clear),
    .InNib(InNib), .InValid(InValid), .InReady(inReady0), .SlotEn(slotEn0),
    .Word(word0), .OutValid(outValid0), .OutReady(OutReady), .Busy(busy0)
  );

  nibble_word_assembler #(.MSB_FIRST(1)) dutMsb (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .Clear(Clear),
    .InNib(InNib), .InValid(InValid), .InReady(inReady1), .SlotEn(slotEn1),
    .Word(word1), .OutValid(outValid1), .OutReady(OutReady), .Busy(busy1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelWord(input bit msbFirst);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < nibs.size(); i++) begin
      if (msbFirst) w = w | (32'(nibs[i]) << (4 * (7 - i)));
      else          w = w | (32'(nibs[i]) << (4 * i));
    end
    return w;
  endfunction

  task automatic modelReset();
    phase = 0;
    nibs.delete();
  endtask

  task automatic modelStep();
    if (Clear) begin
      phase = 0;
      nibs.delete();
    end else if (phase == 0) begin
      if (Start) begin
        phase = 1;
        nibs.delete();
      end
    end else if (phase == 1) begin
      if (InValid) begin
        nibs.push_back(InNib);
        if (nibs.size() == 8) phase = 2;
      end
    end else begin
      if (OutReady) begin
        if (Start) begin
          phase = 1;
          nibs.delete();
        end else begin
          phase = 0;
        end
      end
    end
  endtask

  task automatic checkAll();
    bit         acc;
    logic [7:0] e0, e1;
    acc = ResetN && (phase == 1) && InValid && !Clear;
    e0  = acc ? (8'd1 << nibs.size())       : 8'd0;
    e1  = acc ? (8'd1 << (7 - nibs.size())) : 8'd0;
    chk("slotEnLsb",   32'(slotEn0),   32'(e0));
    chk("slotEnMsb",   32'(slotEn1),   32'(e1));
    chk("wordLsb",     word0,          modelWord(1'b0));
    chk("wordMsb",     word1,          modelWord(1'b1));
    chk("inReadyLsb",  32'(inReady0),  32'(phase == 1));
    chk("inReadyMsb",  32'(inReady1),  32'(phase == 1));
    chk("outValidLsb", 32'(outValid0), 32'(phase == 2));
    chk("outValidMsb", 32'(outValid1), 32'(phase == 2));
    chk("busyLsb",     32'(busy0),     32'(phase != 0));
    chk("busyMsb",     32'(busy1),     32'(phase != 0));
  endtask

  // Check pre-edge outputs, advance the model, move to the next falling edge.
  task automatic tick();
    #1;
    checkAll();
    if (ResetN) modelStep();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idleInputs();
    Start = 1'b0; Clear = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    InNib = 4'($urandom);
  endtask

  task automatic doStart();
    Start = 1'b1; tick(); Start = 1'b0;
  endtask

  task automatic feed(input logic [3:0] n);
    InValid = 1'b1; InNib = n; tick(); InValid = 1'b0; InNib = 4'($urandom);
  endtask

  task automatic asyncReset();
    #2 ResetN = 1'b0;
    modelReset();
    #1;
    chk("rstWordLsb",   word0,            32'h0);
    chk("rstWordMsb",   word1,            32'h0);
    chk("rstOutValid",  32'(outValid0),   32'h0);
    chk("rstInReady",   32'(inReady0),    32'h0);
    chk("rstBusy",      32'(busy1),       32'h0);
    @(negedge Clk);
    InValid = 1'b1; InNib = 4'h5;
    tick();
    InValid = 1'b0;
    ResetN = 1'b1;
    tick();
  endtask

  initial begin
    logic [3:0] digs[8];
    logic [3:0] mixDigits[8];
    mixDigits = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h9};
    idleInputs();
    ResetN = 1'b0;
    modelReset();
    @(negedge Clk);
    tick();
    tick();
    ResetN = 1'b1;
    tick();

    // Stream 1..8 with no bubbles, held in HOLD, then handed over.
    doStart();
    for (int i = 1; i <= 8; i++) feed(4'(i));
    chk("seqWordLsb", word0, 32'h87654321);
    chk("seqWordMsb", word1, 32'h12345678);
    repeat (3) tick();
    OutReady = 1'b1; tick(); OutReady = 1'b0;
    tick();

    // Digits with random InValid gaps.
    doStart();
    for (int i = 0; i < 8; i++) begin
      while ($urandom_range(0, 2) != 0) tick();
      feed(mixDigits[i]);
    end
    chk("gapWordLsb", word0, 32'h90FEDCBA);
    chk("gapValid",   32'(outValid0), 32'h1);
    tick();

    // Hand-over with Start in the same cycle, then all-F stream.
    OutReady = 1'b1; Start = 1'b1; tick(); OutReady = 1'b0; Start = 1'b0;
    chk("restartWord",    word0, 32'h0);
    chk("restartInReady", 32'(inReady0), 32'h1);
    for (int i = 0; i < 8; i++) feed(4'hF);
    chk("allFWord", word1, 32'hFFFFFFFF);
    OutReady = 1'b1; tick(); OutReady = 1'b0;

    // Clear after five digits while a sixth is presented.
    doStart();
    for (int i = 0; i < 5; i++) feed(4'($urandom));
    Clear = 1'b1; InValid = 1'b1; InNib = 4'h7;
    tick();
    Clear = 1'b0; InValid = 1'b0;
    chk("clrWord", word0, 32'h0);
    chk("clrBusy", 32'(busy0), 32'h0);
    tick();
    doStart();
    for (int i = 0; i < 8; i++) begin
      digs[i] = 4'($urandom);
      feed(digs[i]);
    end
    OutReady = 1'b1; tick(); OutReady = 1'b0;

    // Asynchronous reset mid-fill and in HOLD.
    doStart();
    for (int i = 0; i < 3; i++) feed(4'($urandom));
    asyncReset();
    doStart();
    for (int i = 0; i < 8; i++) feed(4'($urandom));
    tick();
    asyncReset();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      Start    = ($urandom_range(0, 3) == 0);
      Clear    = ($urandom_range(0, 24) == 0);
      InValid  = ($urandom_range(0, 1) == 1);
      OutReady = ($urandom_range(0, 2) == 0);
      InNib    = 4'($urandom);
      tick();
    end
    idleInputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/nibble_word_assembler.md
# nibble_word_assembler

Sequential 1-to-8 nibble distributor: the write-side counterpart of the multiplier's 8:1 4-bit selector. It accepts a stream of eight 4-bit digits over a valid/ready handshake, steers each digit into its slot of a 32-bit word through a one-hot slot decode, and presents the completed word on an output valid/ready handshake. It sits between the multiplier's digit-producing datapath and the 32-bit product/result register path.

## Interface
Parameters:
- MSB_FIRST, 0, slot order: 0 = first accepted nibble lands in Word[3:0] (slot 0 upward); 1 = first nibble lands in Word[31:28] (slot 7 downward)

Ports:
- Clk  input  1  rising-edge clock
- ResetN  input  1  asynchronous, active-low reset
- Start  input  1  begin a new 8-nibble fill (sampled in IDLE, or in HOLD together with OutReady)
- Clear  input  1  synchronous abort: return to IDLE, zero Word
- InNib  input  4  incoming digit
- InValid  input  1  InNib valid
- InReady  output  1  block can accept a nibble this cycle
- SlotEn  output  8  one-hot slot write strobe (combinational), = decode(slot index) & InValid & InReady
- Word  output  32  assembled word
- OutValid  output  1  Word complete and stable
- OutReady  input  1  downstream consumes Word
- Busy  output  1  high in FILL or HOLD

## Operation
- State machine: IDLE, FILL, HOLD. 3-bit nibble counter Cnt.
- Slot index = Cnt when MSB_FIRST=0, else 7 - Cnt.
- IDLE: InReady=0, OutValid=0. Start=1 -> FILL, Cnt<=0, Word<=0.
- FILL: InReady=1. Accept = InValid & InReady. On accept: Word[4*slot+3 : 4*slot] <= InNib; other nibbles unchanged; Cnt<=Cnt+1. Accept with Cnt=7 -> HOLD, Cnt wraps to 0. No accept -> stay, nothing changes. Start ignored in FILL.
- HOLD: InReady=0, OutValid=1, Word frozen. OutReady=1 -> IDLE; OutReady=1 and Start=1 -> FILL directly, Cnt<=0, Word<=0. OutReady=0 -> stay indefinitely.
- Clear=1 in any state: next state IDLE, Cnt<=0, Word<=0; Clear has priority over Start, accept and OutReady in the same cycle (a nibble presented that cycle is dropped; SlotEn still forced 0 when Clear=1).
- SlotEn is exactly one-hot on an accepting cycle, all-zero otherwise.
- No arithmetic on data; nibbles are stored unmodified, no width extension.

## Timing
- Reset (ResetN=0, asynchronous): state IDLE, Cnt=0, Word=32'h0, OutValid=0, InReady=0, Busy=0; SlotEn=0 while in reset. Deassertion takes effect on the next Clk edge.
- Reset asserted mid-fill or in HOLD: partial/complete word discarded immediately.
- Start at edge N -> InReady=1 from cycle N+1.
- Nibble accepted at edge E -> visible on Word after E.
- 8th accept at edge E -> OutValid=1 and InReady=0 from E; minimum fill-to-valid latency 8 cycles after entering FILL (one nibble per cycle, no bubbles required).
- Word handed over at the edge where OutValid & OutReady; OutValid drops after that edge unless Start also held (then FILL, OutValid=0, InReady=1).
- Back-to-back words: 9 cycles per word minimum (8 fill + 1 HOLD).
- Busy = (state != IDLE), registered with state.

## Test plan
- Reset then MSB_FIRST=0, Start, nibbles 1,2,...,8 on consecutive cycles with OutReady=0 -> SlotEn sequence 01,02,...,80; after 8th edge OutValid=1, Word=32'h87654321, InReady=0, held until OutReady.
- MSB_FIRST=1, same stream 1..8 -> SlotEn 80,40,...,01; Word=32'h12345678.
- InValid toggled 1-0-1 with random gaps for digits A,B,C,D,E,F,0,9 (MSB_FIRST=0) -> Word=32'h90FEDCBA, Cnt only advances on accepts, OutValid exactly after 8th accept.
- HOLD with OutReady=1 and Start=1 in same cycle -> next cycle FILL, Word=0, OutValid=0, InReady=1; second stream of all 4'hF gives Word=32'hFFFFFFFF.
- After 5 accepted nibbles assert Clear together with InValid=1 -> SlotEn=0, next cycle IDLE, Word=0, Busy=0; new Start refills from slot 0.
- Drop ResetN asynchronously (between edges) during FILL after 3 nibbles and in HOLD -> Word, OutValid, InReady, Busy go 0 immediately; nibbles presented during reset produce no SlotEn.
